// File: rtl/matmul2x2_stream_adapter.sv
// rtl/matmul2x2_stream_adapter.sv - streams two 2x2 operand matrices to a multiply pipe and drains the product
module matmul2x2_stream_adapter #(
    parameter int LATENCY = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  in_data,
    input  logic         in_vld,
    output logic         in_rdy,
    output logic [127:0] mm_a,
    output logic [127:0] mm_b,
    input  logic [383:0] mm_out,
    output logic [31:0]  out_data,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic         err
);
    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int WCW = $clog2(LATENCY + 2);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(LATENCY);

    logic [1:0]     state_q, state_d;
    logic [2:0]     word_cnt_q, word_cnt_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [127:0]   mm_a_q, mm_a_d;
    logic [127:0]   mm_b_q, mm_b_d;
    logic [127:0]   c_q, c_d;
    logic [1:0]     out_idx_q, out_idx_d;
    logic           err_q, err_d;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        wait_cnt_d = wait_cnt_q;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;
        c_d        = c_q;
        out_idx_d  = out_idx_q;
        err_d      = err_q;
        case (state_q)
            S_LOAD: begin
                if (in_vld) begin
                    // words 0-3 fill A, 4-7 fill B, each row-major
                    if (!word_cnt_q[2]) begin
                        mm_a_d[{word_cnt_q[1:0], 5'd0} +: 32] = in_data;
                    end else begin
                        mm_b_d[{word_cnt_q[1:0], 5'd0} +: 32] = in_data;
                    end
                    word_cnt_d = word_cnt_q + 3'd1;
                    if (word_cnt_q == 3'd7) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = '0;
                    end
                end
            end
            S_WAIT: begin
                // the pipe output register holds our product one edge after it updates
                if (wait_cnt_q == WAIT_LAST) begin
                    c_d       = mm_out[127:0];
                    out_idx_d = 2'd0;
                    state_d   = S_DRAIN;
                    if ((mm_out[383:256] != mm_a_q) || (mm_out[255:128] != mm_b_q)) begin
                        err_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_rdy) begin
                    out_idx_d = out_idx_q + 2'd1;
                    if (out_idx_q == 2'd3) begin
                        state_d    = S_LOAD;
                        word_cnt_d = 3'd0;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            word_cnt_q <= '0;
            wait_cnt_q <= '0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            c_q        <= '0;
            out_idx_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
            c_q        <= c_d;
            out_idx_q  <= out_idx_d;
            err_q      <= err_d;
        end
    end

    assign in_rdy   = (state_q == S_LOAD);
    assign out_vld  = (state_q == S_DRAIN);
    assign out_data = c_q[{out_idx_q, 5'd0} +: 32];
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign err      = err_q;
endmodule

// File: tb/tb_matmul2x2_stream_adapter.sv
// tb/tb_matmul2x2_stream_adapter.sv - self-checking bench with a delayed-pipe multiply model
module tb_matmul2x2_stream_adapter;
    localparam int LAT = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  in_data;
    logic         in_vld;
    logic         in_rdy;
    logic [127:0] mm_a;
    logic [127:0] mm_b;
    logic [383:0] mm_out;
    logic [31:0]  out_data;
    logic         out_vld;
    logic         out_rdy;
    logic         err;

    matmul2x2_stream_adapter #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .mm_a(mm_a), .mm_b(mm_b), .mm_out(mm_out),
        .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int edge_e = 0;
    logic corrupt = 1'b0;
    logic [31:0] wa [4];
    logic [31:0] wb [4];

    always @(posedge clk) cyc <= cyc + 1;

    // Environment: a LAT-stage multiply pipe fed from mm_a/mm_b
    function automatic logic [127:0] pipe_mul(input logic [127:0] a, input logic [127:0] b);
        logic [31:0] x [2][2];
        logic [31:0] y [2][2];
        logic [127:0] r;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                x[i][j] = a[32*(2*i+j) +: 32];
                y[i][j] = b[32*(2*i+j) +: 32];
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                r[32*(2*i+j) +: 32] = x[i][0] * y[0][j] + x[i][1] * y[1][j];
        return r;
    endfunction

    logic [383:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= {mm_a, mm_b, pipe_mul(mm_a, mm_b)};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mm_out = {pipe[LAT-1][383:257], pipe[LAT-1][256] ^ corrupt, pipe[LAT-1][255:0]};

    function automatic logic [127:0] pack(input logic [31:0] w [4]);
        return {w[3], w[2], w[1], w[0]};
    endfunction

    function automatic logic [31:0] exp_c(input int idx);
        int i;
        int j;
        i = idx / 2;
        j = idx % 2;
        return wa[2*i] * wb[j] + wa[2*i+1] * wb[2+j];
    endfunction

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_mats(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3);
        wa[0] = a0; wa[1] = a1; wa[2] = a2; wa[3] = a3;
        wb[0] = b0; wb[1] = b1; wb[2] = b2; wb[3] = b3;
    endtask

    task automatic rand_mats();
        for (int k = 0; k < 4; k++) begin
            wa[k] = $urandom;
            wb[k] = $urandom;
        end
    endtask

    task automatic send_all(input bit gaps);
        for (int k = 0; k < 8; k++) begin
            int t;
            t = 0;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_vld = 1'b0;
                step();
            end
            in_vld  = 1'b1;
            in_data = (k < 4) ? wa[k] : wb[k-4];
            while (!in_rdy && t < 50) begin
                step();
                t++;
            end
            check("in_rdy_timeout", {127'd0, in_rdy}, 128'd1);
            if (k == 7) edge_e = cyc + 1;
            step();
        end
        in_vld = 1'b0;
        check("wait_in_rdy", {127'd0, in_rdy}, 128'd0);
        check("mm_a_pack", mm_a, pack(wa));
        check("mm_b_pack", mm_b, pack(wb));
    endtask

    task automatic drain(input int n_words, input bit stalls, input bit chk_lat);
        for (int w = 0; w < n_words; w++) begin
            int t;
            t = 0;
            while (!out_vld && t < 50) begin
                step();
                t++;
            end
            check("out_vld_timeout", {127'd0, out_vld}, 128'd1);
            if (w == 0 && chk_lat) check("first_vld_latency", 128'(cyc - edge_e), 128'(LAT + 1));
            check($sformatf("out_word%0d", w), {96'd0, out_data}, {96'd0, exp_c(w)});
            if (stalls) begin
                int n;
                n = $urandom_range(0, 2);
                for (int s = 0; s < n; s++) begin
                    out_rdy = 1'b0;
                    step();
                    check("stall_hold", {96'd0, out_data}, {96'd0, exp_c(w)});
                end
            end
            out_rdy = 1'b1;
            step();
            out_rdy = 1'b0;
        end
    endtask

    task automatic full_product(input bit gaps, input bit stalls, input bit chk_lat);
        send_all(gaps);
        drain(4, stalls, chk_lat);
        check("post_drain_vld", {127'd0, out_vld}, 128'd0);
        check("post_drain_rdy", {127'd0, in_rdy}, 128'd1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_in_rdy", {127'd0, in_rdy}, 128'd1);
        check("rst_out_vld", {127'd0, out_vld}, 128'd0);
        check("rst_mm_a", mm_a, 128'd0);
        check("rst_mm_b", mm_b, 128'd0);
        check("rst_err", {127'd0, err}, 128'd0);
    endtask

    task automatic quiet_window(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (out_vld) seen++;
        end
        check("no_stray_out_vld", 128'(seen), 128'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_vld = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check("reset_in_rdy", {127'd0, in_rdy}, 128'd1);
        check("reset_out_vld", {127'd0, out_vld}, 128'd0);
        check("reset_err", {127'd0, err}, 128'd0);
        check("reset_mm_a", mm_a, 128'd0);

        // Identity, back-to-back, with latency check
        set_mats(32'd1, 32'd0, 32'd0, 32'd1, 32'd5, 32'd6, 32'd7, 32'd8);
        full_product(1'b0, 1'b0, 1'b1);
        check("identity_err", {127'd0, err}, 128'd0);

        // Signed
        set_mats(32'hFFFFFFFF, 32'd2, 32'd3, 32'hFFFFFFFC, 32'd1, 32'd1, 32'd1, 32'd1);
        full_product(1'b0, 1'b0, 1'b1);
        check("signed_c10_const", {96'd0, exp_c(2)}, {96'd0, 32'hFFFFFFFF});

        // Wrap-around
        set_mats(32'h80000000, 32'd0, 32'd0, 32'd0, 32'd2, 32'd0, 32'd0, 32'd0);
        full_product(1'b0, 1'b0, 1'b0);

        // Backpressure with an offered word that must not be consumed
        rand_mats();
        send_all(1'b0);
        begin
            int t;
            t = 0;
            while (!out_vld && t < 50) begin
                step();
                t++;
            end
        end
        in_vld = 1'b1;
        in_data = $urandom;
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold", {96'd0, out_data}, {96'd0, exp_c(0)});
            check("bp_in_rdy", {127'd0, in_rdy}, 128'd0);
            check("bp_mm_a", mm_a, pack(wa));
        end
        in_vld = 1'b0;
        drain(4, 1'b0, 1'b0);
        check("bp_mm_a_kept", mm_a, pack(wa));
        check("bp_mm_b_kept", mm_b, pack(wb));

        // Reset while waiting on the pipe
        rand_mats();
        send_all(1'b0);
        step();
        step();
        pulse_rst();
        quiet_window(12);

        // Reset after two drained words
        rand_mats();
        send_all(1'b0);
        drain(2, 1'b0, 1'b0);
        pulse_rst();
        quiet_window(10);
        rand_mats();
        full_product(1'b1, 1'b0, 1'b1);

        // Randomized products with gaps and stalls
        for (int r = 0; r < 6; r++) begin
            rand_mats();
            full_product(1'b1, 1'b1, 1'b0);
        end
        check("random_err", {127'd0, err}, 128'd0);

        // Echo fault is sticky until reset
        corrupt = 1'b1;
        rand_mats();
        full_product(1'b0, 1'b0, 1'b0);
        check("echo_err_set", {127'd0, err}, 128'd1);
        corrupt = 1'b0;
        rand_mats();
        full_product(1'b0, 1'b0, 1'b0);
        check("echo_err_sticky", {127'd0, err}, 128'd1);
        pulse_rst();
        rand_mats();
        full_product(1'b0, 1'b0, 1'b0);
        check("echo_err_clear", {127'd0, err}, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/matmul2x2_stream_adapter.md
MATMUL2X2_STREAM_ADAPTER -- requirements
Module: matmul2x2_stream_adapter

Interface
REQ-001 SHALL have parameter LATENCY, default 6: cycles from operand presentation to the 2x2 multiply pipe output register update.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port in_data, input, 32: operand word stream.
REQ-005 SHALL have port in_vld, input, 1: in_data valid.
REQ-006 SHALL have port in_rdy, output, 1: adapter accepts in_data.
REQ-007 SHALL have port mm_a, output, 128: matrix A to the multiply pipe; a[i][j] at bits [32*(2i+j)+31 : 32*(2i+j)].
REQ-008 SHALL have port mm_b, output, 128: matrix B, same packing as mm_a.
REQ-009 SHALL have port mm_out, input, 384: pipe output tuple; [383:256]=A echo, [255:128]=B echo, [127:0]=C=A*B, same packing.
REQ-010 SHALL have port out_data, output, 32: result word stream.
REQ-011 SHALL have port out_vld, output, 1: out_data valid.
REQ-012 SHALL have port out_rdy, input, 1: downstream accepts out_data.
REQ-013 SHALL have port err, output, 1: sticky echo-mismatch flag.

Function
REQ-014 SHALL implement FSM states LOAD, WAIT, DRAIN; one matrix product in flight at a time.
REQ-015 SHALL assert in_rdy only in LOAD; a word transfers on an edge where in_vld and in_rdy are both 1.
REQ-016 SHALL write transfer k (k=0..7, counted by a 3-bit counter) into mm_a word k for k<4, else mm_b word k-4; word 0 = a[0][0], word 1 = a[0][1], word 2 = a[1][0], word 3 = a[1][1]; B words in the same order.
REQ-017 SHALL hold mm_a/mm_b as registers, stable from transfer 7 until the next LOAD transfer 0.
REQ-018 SHALL move LOAD->WAIT on the edge E that accepts transfer 7.
REQ-019 SHALL, in WAIT, count edges and capture mm_out[383:0] on edge E+LATENCY+1, then move to DRAIN on that same edge.
REQ-020 SHALL, on capture, set err if captured A echo != mm_a or B echo != mm_b; err stays set until rst.
REQ-021 SHALL, in DRAIN, present captured C words in order c00, c01, c10, c11 (C bits [31:0] first) with out_vld=1.
REQ-022 SHALL hold out_data stable while out_vld=1 and out_rdy=0; advance only on an edge with out_vld and out_rdy both 1.
REQ-023 SHALL return DRAIN->LOAD on the edge accepting c11, with the word counter at 0; in_rdy=1 on the next cycle.
REQ-024 SHALL not combinationally couple out_rdy to in_rdy, or in_vld to out_vld.
REQ-025 SHALL pass C through unmodified: 32-bit two's-complement, wrap-around modulo 2^32 as produced by the pipe.
REQ-026 SHALL ignore in_vld outside LOAD; words offered then are neither consumed nor lost (in_rdy=0).

Reset
REQ-027 SHALL, on rst=1 at an edge, enter LOAD, clear word and wait counters, mm_a=0, mm_b=0, captured C=0, out_vld=0, err=0, in_rdy=1 after that edge.
REQ-028 SHALL abort any in-progress LOAD, WAIT or DRAIN on rst; partial operands and undrained results are discarded.
REQ-029 SHALL give rst priority over any simultaneous in or out handshake.

Verification
REQ-030 Identity: A=[1,0;0,1], B=[5,6;7,8] streamed back-to-back -> out 5,6,7,8; out_vld first high 1 cycle after edge E+7; err=0.
REQ-031 Signed: A=[-1,2;3,-4], B=[1,1;1,1] -> out 0x00000001, 0x00000001, 0xFFFFFFFF, 0xFFFFFFFF.
REQ-032 Wrap: A=[0x80000000,0;0,0], B=[2,0;0,0] -> c00=0x00000000, all others 0.
REQ-033 Backpressure: out_rdy=0 for 5 cycles during DRAIN, with in_vld=1 throughout -> out_data held, in_rdy=0, no input consumed; then all 4 words delivered in order.
REQ-034 Reset mid-op: rst pulsed in WAIT, then in DRAIN after 2 words -> no further out_vld, in_rdy=1 next cycle; a fresh product is then correct.
REQ-035 Echo fault: bench corrupts mm_out[256] at capture -> err=1 and stays 1 across subsequent good products until rst.
